// File: rtl/ex_stage.sv
// RV64 execute stage: operand forwarding, ALU, branch resolution, iterative shift-add MUL
// and the EX/MEM pipeline register.
module ex_stage #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MUL_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid_in,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic [6:0]      funct7_in,
  input  logic            ALU_src_in,
  input  logic            Mem_to_Reg_in,
  input  logic            Reg_Write_in,
  input  logic            Mem_Read_in,
  input  logic            Mem_Write_in,
  input  logic            Branch_en_in,
  input  logic [XLEN-1:0] PC_in,
  input  logic [XLEN-1:0] ValA_in,
  input  logic [XLEN-1:0] ValB_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      rd_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_wdata,
  input  logic            flush,
  output logic            stall_out,
  output logic            instr_valid_out,
  output logic            Mem_to_Reg_out,
  output logic            Reg_Write_out,
  output logic            Mem_Read_out,
  output logic            Mem_Write_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic [2:0]      funct3_out,
  output logic            branch_taken_out,
  output logic [XLEN-1:0] branch_target_out
);
  localparam int unsigned CW = $clog2(MUL_CYCLES);
  localparam int unsigned SW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic {S_IDLE = 1'b0, S_MUL_BUSY = 1'b1} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_mul_rd;
  logic [2:0]      r_mul_f3;
  logic            r_mul_m2r;
  logic            r_mul_rw;
  logic            r_mul_mr;
  logic            r_mul_mw;

  logic            w_exmem_ok;
  logic            w_memwb_ok;
  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_res;
  logic [XLEN-1:0] w_acc_next;
  logic            w_legal;
  logic            w_is_mul;
  logic            w_cmp;
  logic            w_taken;

  function automatic logic [XLEN-1:0] alu_op(input logic [2:0] f3, input logic alt,
                                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [SW-1:0]          sh;
    logic signed [XLEN-1:0] sra_v;
    logic [XLEN-1:0]        res;
    sh    = b[SW-1:0];
    sra_v = $signed(a) >>> sh;
    case (f3)
      3'b000:  res = alt ? (a - b) : (a + b);
      3'b001:  res = a << sh;
      3'b010:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  res = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  res = a ^ b;
      3'b101:  res = alt ? $unsigned(sra_v) : (a >> sh);
      3'b110:  res = a | b;
      default: res = a & b;
    endcase
    return res;
  endfunction

  // EX/MEM forwarding beats MEM/WB; loads in EX/MEM have no data yet, x0 is never forwarded
  assign w_exmem_ok = Reg_Write_out && instr_valid_out && !Mem_Read_out && (rd_out != 5'd0);
  assign w_memwb_ok = memwb_reg_write && (memwb_rd != 5'd0);
  assign w_fwd_a = (w_exmem_ok && rd_out == rs1_in)   ? alu_result_out :
                   (w_memwb_ok && memwb_rd == rs1_in) ? memwb_wdata : ValA_in;
  assign w_fwd_b = (w_exmem_ok && rd_out == rs2_in)   ? alu_result_out :
                   (w_memwb_ok && memwb_rd == rs2_in) ? memwb_wdata : ValB_in;
  assign w_op_b  = ALU_src_in ? imm_in : w_fwd_b;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    case (funct3_in)
      3'b000:  w_cmp = (w_fwd_a == w_fwd_b);
      3'b001:  w_cmp = (w_fwd_a != w_fwd_b);
      3'b100:  w_cmp = ($signed(w_fwd_a) <  $signed(w_fwd_b));
      3'b101:  w_cmp = ($signed(w_fwd_a) >= $signed(w_fwd_b));
      3'b110:  w_cmp = (w_fwd_a <  w_fwd_b);
      3'b111:  w_cmp = (w_fwd_a >= w_fwd_b);
      default: w_cmp = 1'b0;
    endcase
  end

  // Decode: unrecognised encodings leave w_legal low and become bubbles
  always_comb begin
    w_legal   = 1'b0;
    w_is_mul  = 1'b0;
    w_taken   = 1'b0;
    w_alu_res = '0;
    case (opcode_in)
      OP_R: begin
        if (funct7_in == 7'b0000001) begin
          w_is_mul = (funct3_in == 3'b000);
        end else if (funct7_in == 7'b0000000) begin
          w_legal   = 1'b1;
          w_alu_res = alu_op(funct3_in, 1'b0, w_fwd_a, w_op_b);
        end else if (funct7_in == 7'b0100000 && (funct3_in == 3'b000 || funct3_in == 3'b101)) begin
          w_legal   = 1'b1;
          w_alu_res = alu_op(funct3_in, 1'b1, w_fwd_a, w_op_b);
        end
      end
      OP_I: begin
        w_legal   = 1'b1;
        w_alu_res = alu_op(funct3_in, (funct3_in == 3'b101) && funct7_in[5], w_fwd_a, w_op_b);
      end
      OP_LD, OP_ST: begin
        w_legal   = 1'b1;
        w_alu_res = w_fwd_a + imm_in;
      end
      OP_BR: begin
        w_legal = 1'b1;
        w_taken = Branch_en_in && w_cmp;
      end
      default: ;
    endcase
  end

  assign stall_out = !reset && !flush &&
                     ((r_state == S_MUL_BUSY) ? (r_cnt != CNT_LAST) : (instr_valid_in && w_is_mul));

  // MUL sequencer and EX/MEM register; every path not loading a result loads a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_mcand           <= '0;
      r_mplier          <= '0;
      r_acc             <= '0;
      r_cnt             <= '0;
      r_mul_rd          <= '0;
      r_mul_f3          <= '0;
      r_mul_m2r         <= 1'b0;
      r_mul_rw          <= 1'b0;
      r_mul_mr          <= 1'b0;
      r_mul_mw          <= 1'b0;
      instr_valid_out   <= 1'b0;
      Mem_to_Reg_out    <= 1'b0;
      Reg_Write_out     <= 1'b0;
      Mem_Read_out      <= 1'b0;
      Mem_Write_out     <= 1'b0;
      alu_result_out    <= '0;
      store_data_out    <= '0;
      rd_out            <= '0;
      funct3_out        <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else begin
      instr_valid_out   <= 1'b0;
      Mem_to_Reg_out    <= 1'b0;
      Reg_Write_out     <= 1'b0;
      Mem_Read_out      <= 1'b0;
      Mem_Write_out     <= 1'b0;
      alu_result_out    <= '0;
      store_data_out    <= '0;
      rd_out            <= '0;
      funct3_out        <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
      if (flush) begin
        r_state <= S_IDLE;
      end else if (r_state == S_MUL_BUSY) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (r_cnt == CNT_LAST) begin
          r_state           <= S_IDLE;
          instr_valid_out   <= 1'b1;
          alu_result_out    <= w_acc_next;
          store_data_out    <= w_fwd_b;
          rd_out            <= r_mul_rd;
          funct3_out        <= r_mul_f3;
          Mem_to_Reg_out    <= r_mul_m2r;
          Reg_Write_out     <= r_mul_rw;
          Mem_Read_out      <= r_mul_mr;
          Mem_Write_out     <= r_mul_mw;
          branch_target_out <= PC_in + imm_in;
        end
      end else if (instr_valid_in && w_is_mul) begin
        r_state   <= S_MUL_BUSY;
        r_mcand   <= w_fwd_a;
        r_mplier  <= w_fwd_b;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_mul_rd  <= rd_in;
        r_mul_f3  <= funct3_in;
        r_mul_m2r <= Mem_to_Reg_in;
        r_mul_rw  <= Reg_Write_in;
        r_mul_mr  <= Mem_Read_in;
        r_mul_mw  <= Mem_Write_in;
      end else if (instr_valid_in && w_legal) begin
        instr_valid_out   <= 1'b1;
        Mem_to_Reg_out    <= Mem_to_Reg_in;
        Reg_Write_out     <= Reg_Write_in;
        Mem_Read_out      <= Mem_Read_in;
        Mem_Write_out     <= Mem_Write_in;
        alu_result_out    <= w_alu_res;
        store_data_out    <= w_fwd_b;
        rd_out            <= rd_in;
        funct3_out        <= funct3_in;
        branch_taken_out  <= w_taken;
        branch_target_out <= PC_in + imm_in;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized instructions
// checked against a mnemonic-level reference model.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [6:0]  funct7_in;
  logic        ALU_src_in, Mem_to_Reg_in, Reg_Write_in, Mem_Read_in, Mem_Write_in, Branch_en_in;
  logic [63:0] PC_in, ValA_in, ValB_in, imm_in;
  logic [4:0]  rd_in, rs1_in, rs2_in, memwb_rd;
  logic        memwb_reg_write;
  logic [63:0] memwb_wdata;
  logic        flush;
  logic        stall_out, instr_valid_out, Mem_to_Reg_out, Reg_Write_out, Mem_Read_out, Mem_Write_out;
  logic [63:0] alu_result_out, store_data_out, branch_target_out;
  logic [4:0]  rd_out;
  logic [2:0]  funct3_out;
  logic        branch_taken_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .instr_valid_in(instr_valid_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .funct7_in(funct7_in), .ALU_src_in(ALU_src_in),
    .Mem_to_Reg_in(Mem_to_Reg_in), .Reg_Write_in(Reg_Write_in), .Mem_Read_in(Mem_Read_in),
    .Mem_Write_in(Mem_Write_in), .Branch_en_in(Branch_en_in), .PC_in(PC_in), .ValA_in(ValA_in),
    .ValB_in(ValB_in), .imm_in(imm_in), .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_wdata(memwb_wdata),
    .flush(flush), .stall_out(stall_out), .instr_valid_out(instr_valid_out),
    .Mem_to_Reg_out(Mem_to_Reg_out), .Reg_Write_out(Reg_Write_out), .Mem_Read_out(Mem_Read_out),
    .Mem_Write_out(Mem_Write_out), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .rd_out(rd_out), .funct3_out(funct3_out), .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out)
  );

  typedef enum int {
    M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
    M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
    M_LD, M_SD, M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU, M_BAD, M_MUL
  } mnem_t;

  localparam logic [63:0] NEG2  = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] NEG3  = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] NEG7  = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] NEG21 = 64'hFFFF_FFFF_FFFF_FFEB;

  task automatic drive(input mnem_t m, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] imm, input logic [63:0] pc);
    instr_valid_in = 1'b1;
    rd_in = rd; rs1_in = rs1; rs2_in = rs2;
    ValA_in = a; ValB_in = b; imm_in = imm; PC_in = pc;
    opcode_in = 7'b0110011; funct7_in = 7'b0000000;
    ALU_src_in = 1'b0; Mem_to_Reg_in = 1'b0; Reg_Write_in = 1'b0;
    Mem_Read_in = 1'b0; Mem_Write_in = 1'b0; Branch_en_in = 1'b0;
    case (m)
      M_ADD, M_SUB, M_ADDI, M_BEQ, M_MUL:         funct3_in = 3'b000;
      M_SLL, M_SLLI, M_BNE:                       funct3_in = 3'b001;
      M_SLT, M_SLTI:                              funct3_in = 3'b010;
      M_SLTU, M_SLTIU, M_LD, M_SD:                funct3_in = 3'b011;
      M_XOR, M_XORI, M_BLT:                       funct3_in = 3'b100;
      M_SRL, M_SRA, M_SRLI, M_SRAI, M_BGE:        funct3_in = 3'b101;
      M_OR, M_ORI, M_BLTU:                        funct3_in = 3'b110;
      default:                                    funct3_in = 3'b111;
    endcase
    if (m == M_SUB || m == M_SRA || m == M_SRAI) funct7_in = 7'b0100000;
    if (m == M_MUL) funct7_in = 7'b0000001;
    if (m <= M_AND || m == M_MUL) begin
      Reg_Write_in = 1'b1;
    end else if (m <= M_SRAI) begin
      opcode_in = 7'b0010011; ALU_src_in = 1'b1; Reg_Write_in = 1'b1;
    end else if (m == M_LD) begin
      opcode_in = 7'b0000011; ALU_src_in = 1'b1; Reg_Write_in = 1'b1;
      Mem_Read_in = 1'b1; Mem_to_Reg_in = 1'b1;
    end else if (m == M_SD) begin
      opcode_in = 7'b0100011; ALU_src_in = 1'b1; Mem_Write_in = 1'b1;
    end else if (m <= M_BGEU) begin
      opcode_in = 7'b1100011; Branch_en_in = 1'b1;
    end else begin
      opcode_in = 7'b1111111; Reg_Write_in = 1'b1; Mem_Write_in = 1'b1;
    end
  endtask

  // Architectural meaning of each mnemonic, given the true operand values
  function automatic logic [63:0] ref_result(input mnem_t m, input logic [63:0] a,
                                             input logic [63:0] rb, input logic [63:0] imm);
    logic [63:0]        b;
    logic signed [63:0] sra_v;
    logic [63:0]        r;
    b = (m >= M_ADDI && m <= M_SD) ? imm : rb;
    sra_v = $signed(a) >>> b[5:0];
    case (m)
      M_ADD, M_ADDI, M_LD, M_SD: r = a + b;
      M_SUB:                     r = a - b;
      M_SLL, M_SLLI:             r = a << b[5:0];
      M_SLT, M_SLTI:             r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      M_SLTU, M_SLTIU:           r = (a < b) ? 64'd1 : 64'd0;
      M_XOR, M_XORI:             r = a ^ b;
      M_SRL, M_SRLI:             r = a >> b[5:0];
      M_SRA, M_SRAI:             r = $unsigned(sra_v);
      M_OR, M_ORI:               r = a | b;
      M_AND, M_ANDI:             r = a & b;
      M_MUL:                     r = a * rb;
      default:                   r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_taken(input mnem_t m, input logic [63:0] a, input logic [63:0] b);
    case (m)
      M_BEQ:   return a == b;
      M_BNE:   return a != b;
      M_BLT:   return $signed(a) < $signed(b);
      M_BGE:   return $signed(a) >= $signed(b);
      M_BLTU:  return a < b;
      M_BGEU:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'(unsigned'($urandom_range(0, 70)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic idle_cycle();
    instr_valid_in = 1'b0; memwb_reg_write = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
  endtask

  // Waits for a multiply to leave EX; reports edges taken, stall-high cycles and non-bubble cycles
  task automatic mul_wait(output int edges, output int stall_hi, output int bubble_bad);
    edges = 0; stall_hi = 0; bubble_bad = 0;
    for (int i = 0; i < 150; i++) begin
      #1;
      if (stall_out) stall_hi++;
      @(posedge clk); #1;
      edges++;
      if (instr_valid_out) break;
      if (Reg_Write_out || Mem_Write_out || Mem_Read_out || branch_taken_out) bubble_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; instr_valid_in = 1'b0; memwb_reg_write = 1'b0;
    memwb_rd = 5'd0; memwb_wdata = 64'd0;
    drive(M_ADD, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    instr_valid_in = 1'b0;
    #12;
    n_checks++;
    if ({instr_valid_out, Reg_Write_out, Mem_Read_out, Mem_Write_out, Mem_to_Reg_out,
         branch_taken_out, stall_out} !== 7'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000000", {instr_valid_out, Reg_Write_out,
        Mem_Read_out, Mem_Write_out, Mem_to_Reg_out, branch_taken_out, stall_out});
    end
    n_checks++;
    if ({alu_result_out, store_data_out, branch_target_out, rd_out, funct3_out} !== '0) begin
      n_fail++; $display("FAIL reset_data: alu=%h st=%h tgt=%h rd=%0d", alu_result_out,
        store_data_out, branch_target_out, rd_out);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    idle_cycle();
    drive(M_ADD, 5'd3, 5'd1, 5'd2, 64'd5, NEG7, 64'd0, 64'h40);
    @(posedge clk); #1;
    n_checks++;
    if (alu_result_out !== NEG2) begin
      n_fail++; $display("FAIL add_result: got %h required %h", alu_result_out, NEG2);
    end
    n_checks++;
    if ({instr_valid_out, Reg_Write_out, rd_out} !== {1'b1, 1'b1, 5'd3}) begin
      n_fail++; $display("FAIL add_ctrl: valid=%b rw=%b rd=%0d required 1 1 3",
        instr_valid_out, Reg_Write_out, rd_out);
    end
    drive(M_ADD, 5'd3, 5'd1, 5'd2, 64'd5, NEG7, 64'd0, 64'h40);
    instr_valid_in = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({instr_valid_out, Reg_Write_out} !== 2'b00) begin
      n_fail++; $display("FAIL invalid_in_bubble: valid=%b rw=%b required 0 0", instr_valid_out, Reg_Write_out);
    end
    drive(M_BAD, 5'd3, 5'd1, 5'd2, 64'd5, NEG7, 64'd0, 64'h40);
    @(posedge clk); #1;
    n_checks++;
    if ({instr_valid_out, Reg_Write_out, Mem_Write_out} !== 3'b000) begin
      n_fail++; $display("FAIL illegal_bubble: valid=%b rw=%b mw=%b required 0 0 0",
        instr_valid_out, Reg_Write_out, Mem_Write_out);
    end
  endtask

  task automatic test_forwarding();
    idle_cycle();
    drive(M_ADD, 5'd3, 5'd1, 5'd2, 64'd5, NEG7, 64'd0, 64'd0);
    @(posedge clk); #1;
    drive(M_SUB, 5'd4, 5'd3, 5'd3, 64'd99, 64'd7, 64'd0, 64'd0);
    @(posedge clk); #1;
    n_checks++;
    if (alu_result_out !== 64'd0 || rd_out !== 5'd4) begin
      n_fail++; $display("FAIL fwd_exmem: got %h rd=%0d required 0 rd=4", alu_result_out, rd_out);
    end
    drive(M_ADD, 5'd3, 5'd1, 5'd2, 64'd5, NEG7, 64'd0, 64'd0);
    @(posedge clk); #1;
    drive(M_ADD, 5'd4, 5'd3, 5'd0, 64'd99, 64'd0, 64'd0, 64'd0);
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_wdata = 64'd1234;
    @(posedge clk); #1;
    n_checks++;
    if (alu_result_out !== NEG2) begin
      n_fail++; $display("FAIL fwd_priority: got %h required %h", alu_result_out, NEG2);
    end
    drive(M_ADD, 5'd5, 5'd3, 5'd0, 64'd99, 64'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    n_checks++;
    if (alu_result_out !== 64'd1234) begin
      n_fail++; $display("FAIL fwd_memwb: got %h required %h", alu_result_out, 64'd1234);
    end
    memwb_reg_write = 1'b0;
    drive(M_ADD, 5'd0, 5'd1, 5'd2, 64'd5, NEG7, 64'd0, 64'd0);
    @(posedge clk); #1;
    drive(M_ADD, 5'd6, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_wdata = 64'd55;
    @(posedge clk); #1;
    n_checks++;
    if (alu_result_out !== 64'd0) begin
      n_fail++; $display("FAIL fwd_x0: got %h required 0", alu_result_out);
    end
    memwb_reg_write = 1'b0;
    drive(M_LD, 5'd7, 5'd0, 5'd0, 64'h1000, 64'd0, 64'd8, 64'd0);
    @(posedge clk); #1;
    n_checks++;
    if ({alu_result_out, Mem_Read_out, Mem_to_Reg_out} !== {64'h1008, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL load_addr: got %h mr=%b m2r=%b required 1008 1 1",
        alu_result_out, Mem_Read_out, Mem_to_Reg_out);
    end
    drive(M_ADD, 5'd8, 5'd7, 5'd0, 64'd77, 64'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    n_checks++;
    if (alu_result_out !== 64'd77) begin
      n_fail++; $display("FAIL no_fwd_load: got %h required %h", alu_result_out, 64'd77);
    end
  endtask

  task automatic test_branch();
    idle_cycle();
    drive(M_BEQ, 5'd0, 5'd1, 5'd2, 64'h10, 64'h10, 64'h20, 64'h100);
    @(posedge clk); #1;
    n_checks++;
    if ({branch_taken_out, branch_target_out, alu_result_out, Reg_Write_out} !== {1'b1, 64'h120, 64'd0, 1'b0}) begin
      n_fail++; $display("FAIL beq_taken: taken=%b tgt=%h res=%h rw=%b required 1 120 0 0",
        branch_taken_out, branch_target_out, alu_result_out, Reg_Write_out);
    end
    drive(M_BLTU, 5'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 64'h100);
    @(posedge clk); #1;
    n_checks++;
    if (branch_taken_out !== 1'b0 || instr_valid_out !== 1'b1) begin
      n_fail++; $display("FAIL bltu_not_taken: taken=%b valid=%b required 0 1", branch_taken_out, instr_valid_out);
    end
    drive(M_BEQ, 5'd0, 5'd1, 5'd2, 64'h10, 64'h10, 64'h20, 64'h100);
    Branch_en_in = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (branch_taken_out !== 1'b0) begin
      n_fail++; $display("FAIL branch_en_off: got %b required 0", branch_taken_out);
    end
    drive(M_BEQ, 5'd0, 5'd1, 5'd2, 64'h10, 64'h10, 64'h20, 64'h100);
    funct3_in = 3'b010;
    @(posedge clk); #1;
    n_checks++;
    if (branch_taken_out !== 1'b0) begin
      n_fail++; $display("FAIL branch_undef_f3: got %b required 0", branch_taken_out);
    end
  endtask

  task automatic test_random_alu();
    logic        p_valid, p_rw, p_mr;
    logic [4:0]  p_rd;
    logic [63:0] p_res;
    idle_cycle();
    p_valid = 1'b0; p_rw = 1'b0; p_mr = 1'b0; p_rd = 5'd0; p_res = 64'd0;
    for (int i = 0; i < 300; i++) begin
      mnem_t       m;
      logic [4:0]  rd, rs1, rs2;
      logic [63:0] a, b, imm, pc, fa, fb, e_res;
      logic        e_valid, e_rw, e_mr, e_mw, e_tk;
      m   = mnem_t'($urandom_range(0, int'(M_BAD)));
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      a = rand64(); b = rand64(); imm = rand64(); pc = {$urandom, $urandom};
      memwb_rd = 5'($urandom_range(0, 7));
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_wdata = rand64();
      fa = (p_valid && p_rw && !p_mr && p_rd != 5'd0 && p_rd == rs1) ? p_res :
           (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs1) ? memwb_wdata : a;
      fb = (p_valid && p_rw && !p_mr && p_rd != 5'd0 && p_rd == rs2) ? p_res :
           (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs2) ? memwb_wdata : b;
      e_valid = (m != M_BAD);
      e_res   = ref_result(m, fa, fb, imm);
      e_tk    = ref_taken(m, fa, fb);
      e_rw    = (m <= M_SRAI) || (m == M_LD);
      e_mr    = (m == M_LD);
      e_mw    = (m == M_SD);
      drive(m, rd, rs1, rs2, a, b, imm, pc);
      @(posedge clk); #1;
      n_checks++;
      if (instr_valid_out !== e_valid) begin
        n_fail++; $display("FAIL rnd_valid[%0d] op=%0d: got %b required %b", i, m, instr_valid_out, e_valid);
      end
      if (e_valid) begin
        n_checks++;
        if (alu_result_out !== e_res) begin
          n_fail++; $display("FAIL rnd_result[%0d] op=%0d: got %h required %h", i, m, alu_result_out, e_res);
        end
        n_checks++;
        if ({rd_out, Reg_Write_out, Mem_Read_out, Mem_Write_out, branch_taken_out} !==
            {rd, e_rw, e_mr, e_mw, e_tk}) begin
          n_fail++; $display("FAIL rnd_ctrl[%0d] op=%0d: got rd=%0d rw%b mr%b mw%b tk%b required rd=%0d rw%b mr%b mw%b tk%b",
            i, m, rd_out, Reg_Write_out, Mem_Read_out, Mem_Write_out, branch_taken_out, rd, e_rw, e_mr, e_mw, e_tk);
        end
        n_checks++;
        if (store_data_out !== fb || branch_target_out !== pc + imm) begin
          n_fail++; $display("FAIL rnd_store_tgt[%0d]: got %h %h required %h %h", i,
            store_data_out, branch_target_out, fb, pc + imm);
        end
      end else begin
        n_checks++;
        if ({Reg_Write_out, Mem_Write_out, Mem_Read_out, branch_taken_out} !== 4'b0000) begin
          n_fail++; $display("FAIL rnd_bubble[%0d]: got %b required 0000", i,
            {Reg_Write_out, Mem_Write_out, Mem_Read_out, branch_taken_out});
        end
      end
      p_valid = e_valid; p_rw = e_rw; p_mr = e_mr; p_rd = rd; p_res = e_res;
    end
    memwb_reg_write = 1'b0;
  endtask

  task automatic test_mul();
    int edges, stall_hi, bubble_bad;
    for (int k = 0; k < 5; k++) begin
      logic [63:0] a, b, e;
      a = (k == 0) ? NEG3 : rand64();
      b = (k == 0) ? 64'd7 : rand64();
      e = (k == 0) ? NEG21 : ref_result(M_MUL, a, b, 64'd0);
      idle_cycle();
      drive(M_MUL, 5'd9, 5'd1, 5'd2, a, b, 64'd0, 64'd0);
      mul_wait(edges, stall_hi, bubble_bad);
      n_checks++;
      if (edges !== 65 || stall_hi !== 64 || bubble_bad !== 0) begin
        n_fail++; $display("FAIL mul_timing[%0d]: edges=%0d stall=%0d bad=%0d required 65 64 0",
          k, edges, stall_hi, bubble_bad);
      end
      n_checks++;
      if ({alu_result_out, rd_out, Reg_Write_out} !== {e, 5'd9, 1'b1}) begin
        n_fail++; $display("FAIL mul_result[%0d]: got %h rd=%0d rw=%b required %h rd=9 rw=1",
          k, alu_result_out, rd_out, Reg_Write_out, e);
      end
      instr_valid_in = 1'b0; #1;
      n_checks++;
      if (stall_out !== 1'b0) begin
        n_fail++; $display("FAIL mul_stall_drop[%0d]: got %b required 0", k, stall_out);
      end
    end
  endtask

  task automatic test_mul_flush();
    idle_cycle();
    drive(M_MUL, 5'd9, 5'd1, 5'd2, NEG3, 64'd7, 64'd0, 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; #1;
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b required 0", stall_out);
    end
    @(posedge clk); #1;
    flush = 1'b0; instr_valid_in = 1'b0;
    n_checks++;
    if ({instr_valid_out, Reg_Write_out} !== 2'b00) begin
      n_fail++; $display("FAIL flush_bubble: valid=%b rw=%b required 0 0", instr_valid_out, Reg_Write_out);
    end
    drive(M_ADD, 5'd3, 5'd1, 5'd2, 64'd5, NEG7, 64'd0, 64'd0);
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_fsm_idle: stall=%b required 0", stall_out);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({instr_valid_out, alu_result_out} !== {1'b1, NEG2}) begin
      n_fail++; $display("FAIL flush_then_add: valid=%b got %h required 1 %h", instr_valid_out, alu_result_out, NEG2);
    end
  endtask

  task automatic test_reset_mid_mul();
    idle_cycle();
    drive(M_MUL, 5'd9, 5'd1, 5'd2, NEG3, 64'd7, 64'd0, 64'd0);
    repeat (20) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({stall_out, instr_valid_out, alu_result_out} !== '0) begin
      n_fail++; $display("FAIL reset_mid_mul: stall=%b valid=%b res=%h required 0", stall_out, instr_valid_out, alu_result_out);
    end
    instr_valid_in = 1'b0;
    @(negedge clk); reset = 1'b0;
    drive(M_SRA, 5'd10, 5'd1, 5'd2, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd0);
    @(posedge clk); #1;
    n_checks++;
    if ({instr_valid_out, alu_result_out} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_fail++; $display("FAIL sra_after_reset: valid=%b got %h required 1 ffffffffffffffff", instr_valid_out, alu_result_out);
    end
    instr_valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({instr_valid_out, Reg_Write_out, rd_out, alu_result_out} !== '0) begin
      n_fail++; $display("FAIL async_reset_clear: valid=%b rw=%b rd=%0d res=%h required 0",
        instr_valid_out, Reg_Write_out, rd_out, alu_result_out);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_branch();
    test_random_alu();
    test_mul();
    test_mul_flush();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
